// File: rtl/pmp_seq_check.sv
// Iterative PMP permission checker: walks the PMP entries in priority order,
// one entry per cycle, and returns an allow/deny decision for one access.
package riscv;
  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    TOR   = 2'b01,
    NA4   = 2'b10,
    NAPOT = 2'b11
  } pmp_addr_mode_t;

  typedef struct packed {
    logic x;
    logic w;
    logic r;
  } pmpcfg_access_t;

  typedef struct packed {
    logic           locked;
    pmp_addr_mode_t addr_mode;
    pmpcfg_access_t access_type;
  } pmpcfg_t;
endpackage

module pmp_seq_check #(
  parameter int unsigned PLEN       = 56,
  parameter int unsigned PMP_LEN    = 54,
  parameter int unsigned NR_ENTRIES = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [PLEN-1:0]                 req_addr_i,
  input  logic [2:0]                      req_access_i,
  input  riscv::priv_lvl_t                req_priv_i,
  input  logic [PMP_LEN-1:0]              conf_addr_i [NR_ENTRIES],
  input  riscv::pmpcfg_t                  conf_i      [NR_ENTRIES],
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic                            rsp_allow_o,
  output logic                            rsp_match_o,
  output logic [((NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1)-1:0] rsp_entry_o
);

  localparam int unsigned EW = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
  localparam int unsigned IW = $clog2(NR_ENTRIES) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [PLEN-1:0]  addr_q, addr_d;
  logic [2:0]       access_q, access_d;
  riscv::priv_lvl_t priv_q, priv_d;
  logic             allow_q, allow_d;
  logic             match_q, match_d;
  logic [EW-1:0]    entry_q, entry_d;

  logic [EW-1:0]        sel;
  logic [PMP_LEN-1:0]   cur_pa;
  logic [PMP_LEN-1:0]   prev_pa;
  riscv::pmpcfg_t       cur_cfg;
  logic [PLEN-1:0]      cur_base;
  logic [PLEN-1:0]      prev_base;
  logic [PLEN-1:0]      napot_mask;
  logic [2:0]           perm_bits;
  logic                 entry_hit;
  logic                 hit_allow;
  logic                 last_entry;
  int                   tones;
  int                   napot_size;
  logic                 seen_zero;

  assign sel        = idx_q[EW-1:0];
  assign cur_pa     = conf_addr_i[sel];
  assign cur_cfg    = conf_i[sel];
  assign prev_pa    = (idx_q == '0) ? '0 : conf_addr_i[sel - EW'(1)];
  assign cur_base   = PLEN'({cur_pa, 2'b00});
  assign prev_base  = PLEN'({prev_pa, 2'b00});
  assign perm_bits  = cur_cfg.access_type;
  assign last_entry = (idx_q == IW'(NR_ENTRIES - 1));

  // NAPOT region size comes from the run of trailing ones in pmpaddr.
  always_comb begin
    tones     = 0;
    seen_zero = 1'b0;
    for (int i = 0; i < int'(PMP_LEN); i++) begin
      if (!seen_zero && cur_pa[i]) tones = tones + 1;
      else seen_zero = 1'b1;
    end
    napot_size = tones + 3;
    napot_mask = '0;
    for (int i = 0; i < int'(PLEN); i++) begin
      napot_mask[i] = (i >= napot_size);
    end

    entry_hit = 1'b0;
    case (cur_cfg.addr_mode)
      riscv::TOR:   entry_hit = (addr_q >= prev_base) && (addr_q < cur_base);
      riscv::NA4:   entry_hit = (addr_q[PLEN-1:2] == cur_base[PLEN-1:2]);
      riscv::NAPOT: entry_hit = ((addr_q & napot_mask) == (cur_base & napot_mask));
      default:      entry_hit = 1'b0;
    endcase

    hit_allow = ((priv_q == riscv::PRIV_LVL_M) && !cur_cfg.locked) ||
                ((access_q & ~perm_bits) == 3'b000);
  end

  assign req_ready_o = (state_q == IDLE) && !flush_i;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_allow_o = allow_q;
  assign rsp_match_o = match_q;
  assign rsp_entry_o = entry_q;

  // Flush wins over both the response handshake and a new request.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    access_d = access_q;
    priv_d   = priv_q;
    allow_d  = allow_q;
    match_d  = match_q;
    entry_d  = entry_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          addr_d   = req_addr_i;
          access_d = req_access_i;
          priv_d   = req_priv_i;
          idx_d    = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (entry_hit) begin
          allow_d = hit_allow;
          match_d = 1'b1;
          entry_d = sel;
          state_d = RESP;
        end else if (last_entry) begin
          allow_d = (priv_q == riscv::PRIV_LVL_M);
          match_d = 1'b0;
          entry_d = '0;
          state_d = RESP;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      RESP: begin
        if (flush_i || rsp_ready_i) begin
          allow_d = 1'b0;
          match_d = 1'b0;
          entry_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      addr_q   <= '0;
      access_q <= '0;
      priv_q   <= riscv::PRIV_LVL_U;
      allow_q  <= 1'b0;
      match_q  <= 1'b0;
      entry_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      access_q <= access_d;
      priv_q   <= priv_d;
      allow_q  <= allow_d;
      match_q  <= match_d;
      entry_q  <= entry_d;
    end
  end

endmodule

// File: tb/tb_pmp_seq_check.sv
// Directed self-checking bench for pmp_seq_check: latency, match modes,
// priority, lock rules, back-pressure, flush and reset.
module tb_pmp_seq_check;

  localparam int PLEN = 56;
  localparam int PMP_LEN = 54;
  localparam int NR = 16;

  logic                clk;
  logic                rst_n;
  logic                flush;
  logic                req_valid;
  logic                req_ready;
  logic [PLEN-1:0]     req_addr;
  logic [2:0]          req_access;
  riscv::priv_lvl_t    req_priv;
  logic [PMP_LEN-1:0]  conf_addr [NR];
  riscv::pmpcfg_t      conf      [NR];
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_allow;
  logic                rsp_match;
  logic [3:0]          rsp_entry;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] ACC_R = 3'b001;
  localparam logic [2:0] ACC_W = 3'b010;
  localparam logic [2:0] ACC_X = 3'b100;

  pmp_seq_check #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_access_i (req_access),
    .req_priv_i   (req_priv),
    .conf_addr_i  (conf_addr),
    .conf_i       (conf),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_allow_o  (rsp_allow),
    .rsp_match_o  (rsp_match),
    .rsp_entry_o  (rsp_entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every PMP entry back to OFF with a zero address.
  task automatic clear_cfg();
    for (int i = 0; i < NR; i++) begin
      conf_addr[i] = '0;
      conf[i]      = '0;
    end
  endtask

  // Issue one request, wait (bounded) for the response and accept it.
  // cyc is the cycle index, relative to the handshake cycle 0, in which
  // rsp_valid_o is first seen high.
  task automatic run_req(input logic [PLEN-1:0] a, input logic [2:0] acc,
                         input riscv::priv_lvl_t p, output int cyc,
                         output logic al, output logic ma, output logic [3:0] en);
    int n;
    @(negedge clk);
    req_addr   = a;
    req_access = acc;
    req_priv   = p;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL rsp_timeout: no rsp_valid_o within %0d cycles", cyc);
      cyc = -1;
    end
    al = rsp_allow;
    ma = rsp_match;
    en = rsp_entry;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_allow, rsp_match, rsp_entry} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_rsp: got %b expected 0000000",
               {rsp_valid, rsp_allow, rsp_match, rsp_entry});
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b expected 1", req_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_no_rsp: rsp_valid got %b expected 0", rsp_valid);
      end
    end
  endtask

  task automatic test_napot();
    int cyc; logic al, ma; logic [3:0] en;
    clear_cfg();
    conf_addr[2] = 54'h2000_01FF;
    conf[2].addr_mode   = riscv::NAPOT;
    conf[2].access_type = 3'b001;

    run_req(56'h8000_0FFC, ACC_R, riscv::PRIV_LVL_U, cyc, al, ma, en);
    checks++;
    if (cyc !== 4 || al !== 1'b1 || ma !== 1'b1 || en !== 4'd2) begin
      errors++;
      $display("[TB] FAIL napot_read: got cyc=%0d allow=%b match=%b entry=%0d expected cyc=4 allow=1 match=1 entry=2",
               cyc, al, ma, en);
    end
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rsp_drop: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, req_ready);
    end

    run_req(56'h8000_0FFC, ACC_W, riscv::PRIV_LVL_U, cyc, al, ma, en);
    checks++;
    if (al !== 1'b0 || ma !== 1'b1 || en !== 4'd2) begin
      errors++;
      $display("[TB] FAIL napot_write: got allow=%b match=%b entry=%0d expected allow=0 match=1 entry=2",
               al, ma, en);
    end

    run_req(56'h8000_1000, ACC_R, riscv::PRIV_LVL_U, cyc, al, ma, en);
    checks++;
    if (cyc !== 17 || al !== 1'b0 || ma !== 1'b0 || en !== 4'd0) begin
      errors++;
      $display("[TB] FAIL napot_outside: got cyc=%0d allow=%b match=%b entry=%0d expected cyc=17 allow=0 match=0 entry=0",
               cyc, al, ma, en);
    end
  endtask

  task automatic test_priority();
    int cyc; logic al, ma; logic [3:0] en;
    clear_cfg();
    conf_addr[0] = 54'h400;
    conf[0].addr_mode   = riscv::TOR;
    conf[0].access_type = 3'b000;
    conf_addr[1] = 54'h1FF;
    conf[1].addr_mode   = riscv::NAPOT;
    conf[1].access_type = 3'b111;

    run_req(56'h800, ACC_R, riscv::PRIV_LVL_U, cyc, al, ma, en);
    checks++;
    if (cyc !== 2 || al !== 1'b0 || ma !== 1'b1 || en !== 4'd0) begin
      errors++;
      $display("[TB] FAIL prio_tor: got cyc=%0d allow=%b match=%b entry=%0d expected cyc=2 allow=0 match=1 entry=0",
               cyc, al, ma, en);
    end

    conf_addr[0] = 54'h0;
    run_req(56'h800, ACC_R, riscv::PRIV_LVL_U, cyc, al, ma, en);
    checks++;
    if (cyc !== 3 || al !== 1'b1 || ma !== 1'b1 || en !== 4'd1) begin
      errors++;
      $display("[TB] FAIL prio_empty_tor: got cyc=%0d allow=%b match=%b entry=%0d expected cyc=3 allow=1 match=1 entry=1",
               cyc, al, ma, en);
    end
  endtask

  task automatic test_all_off();
    int cyc; logic al, ma; logic [3:0] en;
    clear_cfg();
    run_req(56'h1234_5678, ACC_R, riscv::PRIV_LVL_M, cyc, al, ma, en);
    checks++;
    if (cyc !== 17 || al !== 1'b1 || ma !== 1'b0 || en !== 4'd0) begin
      errors++;
      $display("[TB] FAIL off_mmode: got cyc=%0d allow=%b match=%b entry=%0d expected cyc=17 allow=1 match=0 entry=0",
               cyc, al, ma, en);
    end
    run_req(56'h1234_5678, ACC_R, riscv::PRIV_LVL_S, cyc, al, ma, en);
    checks++;
    if (al !== 1'b0 || ma !== 1'b0) begin
      errors++;
      $display("[TB] FAIL off_smode: got allow=%b match=%b expected allow=0 match=0", al, ma);
    end
  endtask

  task automatic test_na4_lock();
    int cyc; logic al, ma; logic [3:0] en;
    clear_cfg();
    conf_addr[3] = 54'h400;
    conf[3].addr_mode   = riscv::NA4;
    conf[3].access_type = 3'b001;
    conf[3].locked      = 1'b1;

    run_req(56'h1000, ACC_X, riscv::PRIV_LVL_M, cyc, al, ma, en);
    checks++;
    if (cyc !== 5 || al !== 1'b0 || ma !== 1'b1 || en !== 4'd3) begin
      errors++;
      $display("[TB] FAIL na4_locked: got cyc=%0d allow=%b match=%b entry=%0d expected cyc=5 allow=0 match=1 entry=3",
               cyc, al, ma, en);
    end

    conf[3].locked = 1'b0;
    run_req(56'h1000, ACC_X, riscv::PRIV_LVL_M, cyc, al, ma, en);
    checks++;
    if (al !== 1'b1 || ma !== 1'b1 || en !== 4'd3) begin
      errors++;
      $display("[TB] FAIL na4_unlocked: got allow=%b match=%b entry=%0d expected allow=1 match=1 entry=3",
               al, ma, en);
    end

    run_req(56'h1004, ACC_X, riscv::PRIV_LVL_M, cyc, al, ma, en);
    checks++;
    if (al !== 1'b1 || ma !== 1'b0 || en !== 4'd0) begin
      errors++;
      $display("[TB] FAIL na4_next_word: got allow=%b match=%b entry=%0d expected allow=1 match=0 entry=0",
               al, ma, en);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    clear_cfg();
    conf_addr[2] = 54'h2000_01FF;
    conf[2].addr_mode   = riscv::NAPOT;
    conf[2].access_type = 3'b001;
    @(negedge clk);
    req_addr = 56'h8000_0004; req_access = ACC_R; req_priv = riscv::PRIV_LVL_U;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_allow !== 1'b1 || rsp_match !== 1'b1 ||
          rsp_entry !== 4'd2 || req_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_rsp[%0d]: got valid=%b allow=%b match=%b entry=%0d ready=%b expected 1 1 1 2 0",
                 i, rsp_valid, rsp_allow, rsp_match, rsp_entry, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_release: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_flush();
    int cyc; logic al, ma; logic [3:0] en;
    logic seen;
    @(negedge clk);
    req_addr = 56'h8000_0FFC; req_access = ACC_R; req_priv = riscv::PRIV_LVL_U;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_blocks_ready: got %b expected 0", req_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_idle: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, req_ready);
    end
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_no_rsp: rsp_valid seen=%b expected 0", seen);
    end
    run_req(56'h8000_0FFC, ACC_R, riscv::PRIV_LVL_U, cyc, al, ma, en);
    checks++;
    if (cyc !== 4 || al !== 1'b1 || ma !== 1'b1 || en !== 4'd2) begin
      errors++;
      $display("[TB] FAIL after_flush: got cyc=%0d allow=%b match=%b entry=%0d expected cyc=4 allow=1 match=1 entry=2",
               cyc, al, ma, en);
    end
  endtask

  task automatic test_reset_mid_scan();
    int cyc; logic al, ma; logic [3:0] en;
    @(negedge clk);
    req_addr = 56'h8000_0FFC; req_access = ACC_R; req_priv = riscv::PRIV_LVL_U;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_scan: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_req(56'h8000_0FFC, ACC_R, riscv::PRIV_LVL_U, cyc, al, ma, en);
    checks++;
    if (cyc !== 4 || al !== 1'b1 || en !== 4'd2) begin
      errors++;
      $display("[TB] FAIL after_reset: got cyc=%0d allow=%b entry=%0d expected cyc=4 allow=1 entry=2",
               cyc, al, en);
    end
  endtask

  initial begin
    flush = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_access = '0;
    req_priv = riscv::PRIV_LVL_U;
    rsp_ready = 1'b0;
    clear_cfg();
    test_reset();
    test_napot();
    test_priority();
    test_all_off();
    test_na4_lock();
    test_backpressure();
    test_flush();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
